// File: rtl/clk_div_gen.sv
// -----------------------------------------------------------------------------
// clk_div_gen
//
// Multi-channel programmable clock divider. Each channel derives, from the
// single system clock, a one-cycle tick pulse once per period and a near-50%
// clock-enable waveform. The period of a channel is D+1 system cycles, where
// D is the divide value programmed through the configuration port.
//
// Optional feature macro: CLKDIV_GLITCHFREE_EN
//   defined   : a ratio change on a running channel is held in a pending
//               register and applied at the next period boundary, so no
//               truncated or stretched period is ever produced.
//   undefined : a ratio change on a running channel takes effect at the
//               write edge and restarts the period; ch_pend is tied to 0.
//
// Parameters
//   CHANNELS : number of independent divider channels (1..16)
//   DIV_W    : width of the per-channel divide value D
//   CH_W     : width of the channel select (2^CH_W >= CHANNELS)
//
// Ports
//   clk      in   system clock, all state updates on the rising edge
//   rst_n    in   asynchronous active-low reset
//   cfg_we   in   configuration write strobe
//   cfg_ch   in   [CH_W]      channel addressed by the write
//   cfg_div  in   [DIV_W]     divide value D to write
//   cfg_en   in   channel enable to write
//   ch_tick  out  [CHANNELS]  one-cycle pulse per period, per channel
//   ch_clk   out  [CHANNELS]  divided waveform, high ceil((D+1)/2) cycles
//   ch_pend  out  [CHANNELS]  a divide change waits for the period boundary
//
// Configuration handshake: cfg_we is a plain strobe with no back-pressure.
// Every cycle in which cfg_we is high at a rising edge is one complete write;
// the block is always ready. Writes addressing cfg_ch >= CHANNELS are
// dropped without touching any state.
// -----------------------------------------------------------------------------
module clk_div_gen #(
    parameter int CHANNELS = 2,
    parameter int DIV_W    = 8,
    parameter int CH_W     = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [DIV_W-1:0]    cfg_div,
    input  logic                cfg_en,
    output logic [CHANNELS-1:0] ch_tick,
    output logic [CHANNELS-1:0] ch_clk,
    output logic [CHANNELS-1:0] ch_pend
);

    // -------------------------------------------------------------------------
    // Per-channel state
    // -------------------------------------------------------------------------
    logic [CHANNELS-1:0][DIV_W-1:0] div_q, div_d;
    logic [CHANNELS-1:0][DIV_W-1:0] cnt_q, cnt_d;
    logic [CHANNELS-1:0]            en_q,  en_d;
`ifdef CLKDIV_GLITCHFREE_EN
    logic [CHANNELS-1:0][DIV_W-1:0] pdiv_q, pdiv_d;
    logic [CHANNELS-1:0]            pend_q, pend_d;
`endif

    // Period-boundary decode: the current cycle is the last one of the period.
    logic [CHANNELS-1:0] wrap;
    // Write strobe decoded per channel; out-of-range channels never match.
    logic [CHANNELS-1:0] wr_hit;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            wrap[i]   = en_q[i] && (cnt_q[i] == div_q[i]);
            wr_hit[i] = cfg_we && (int'(cfg_ch) == i);
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic: counting first, then the write overrides it.
    // -------------------------------------------------------------------------
    always_comb begin
        div_d = div_q;
        cnt_d = cnt_q;
        en_d  = en_q;
`ifdef CLKDIV_GLITCHFREE_EN
        pdiv_d = pdiv_q;
        pend_d = pend_q;
`endif
        for (int i = 0; i < CHANNELS; i++) begin
            // Free-running count, only while enabled.
            if (en_q[i]) begin
                if (wrap[i]) begin
                    cnt_d[i] = '0;
`ifdef CLKDIV_GLITCHFREE_EN
                    // Boundary reached: the queued ratio takes over for the
                    // period that starts now.
                    if (pend_q[i]) begin
                        div_d[i]  = pdiv_q[i];
                        pend_d[i] = 1'b0;
                    end
`endif
                end else begin
                    cnt_d[i] = cnt_q[i] + DIV_W'(1);
                end
            end

            // Configuration write; takes priority over the wrap update above.
            if (wr_hit[i]) begin
                if (!cfg_en) begin
                    en_d[i]  = 1'b0;
                    cnt_d[i] = '0;
`ifdef CLKDIV_GLITCHFREE_EN
                    pend_d[i] = 1'b0;
`endif
                end else if (!en_q[i]) begin
                    en_d[i]  = 1'b1;
                    div_d[i] = cfg_div;
                    cnt_d[i] = '0;
`ifdef CLKDIV_GLITCHFREE_EN
                    pend_d[i] = 1'b0;
`endif
                end else begin
`ifdef CLKDIV_GLITCHFREE_EN
                    // Running channel: queue the new ratio. If this edge is
                    // also a boundary with an older pending value, that older
                    // value is discarded and the divide stays unchanged, so
                    // the newly written value is the one applied next.
                    div_d[i]  = div_q[i];
                    pdiv_d[i] = cfg_div;
                    pend_d[i] = 1'b1;
`else
                    // Running channel: restart immediately with the new ratio.
                    div_d[i] = cfg_div;
                    cnt_d[i] = '0;
`endif
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            cnt_q <= '0;
            en_q  <= '0;
        end else begin
            div_q <= div_d;
            cnt_q <= cnt_d;
            en_q  <= en_d;
        end
    end

`ifdef CLKDIV_GLITCHFREE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pdiv_q <= '0;
            pend_q <= '0;
        end else begin
            pdiv_q <= pdiv_d;
            pend_q <= pend_d;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Outputs: pure decodes of state flops, no combinational path from cfg_*.
    // Because reset clears en_q asynchronously, all outputs drop at once.
    // -------------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            ch_tick[i] = wrap[i];
            // High for phases 0..D/2, i.e. ceil((D+1)/2) cycles per period.
            ch_clk[i]  = en_q[i] && (cnt_q[i] <= (div_q[i] >> 1));
        end
    end

`ifdef CLKDIV_GLITCHFREE_EN
    assign ch_pend = pend_q;
`else
    assign ch_pend = '0;
`endif

endmodule

// File: tb/tb_clk_div_gen.sv
// -----------------------------------------------------------------------------
// tb_clk_div_gen
//
// Drives clk_div_gen with directed scenarios followed by randomized writes and
// compares every output bit of every channel, every cycle, against a
// reference model that describes each channel by the edge at which its
// current period started and its ratio; expected outputs are derived from the
// phase (edges since period start) modulo (D+1).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_clk_div_gen;

    localparam int CHANNELS = 2;
    localparam int DIV_W    = 8;
    localparam int CH_W     = 4;

    // ---------------------------------------------------------------- clock/reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                cfg_we  = 1'b0;
    logic [CH_W-1:0]     cfg_ch  = '0;
    logic [DIV_W-1:0]    cfg_div = '0;
    logic                cfg_en  = 1'b0;
    logic [CHANNELS-1:0] ch_tick;
    logic [CHANNELS-1:0] ch_clk;
    logic [CHANNELS-1:0] ch_pend;

    clk_div_gen #(.CHANNELS(CHANNELS), .DIV_W(DIV_W), .CH_W(CH_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cfg_we  (cfg_we),
        .cfg_ch  (cfg_ch),
        .cfg_div (cfg_div),
        .cfg_en  (cfg_en),
        .ch_tick (ch_tick),
        .ch_clk  (ch_clk),
        .ch_pend (ch_pend)
    );

    // ---------------------------------------------------------------- scoreboard
    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // ---------------------------------------------------------------- reference model
    int edge_n;
    bit m_en   [CHANNELS];
    int m_d    [CHANNELS];
    int m_s    [CHANNELS];   // edge after which the current period began
    bit m_pend [CHANNELS];
    int m_pdiv [CHANNELS];

    function automatic void model_reset();
        for (int c = 0; c < CHANNELS; c++) begin
            m_en[c] = 0; m_d[c] = 0; m_s[c] = 0; m_pend[c] = 0; m_pdiv[c] = 0;
        end
    endfunction

    function automatic int phase_of(input int c, input int n);
        return (n - m_s[c]) % (m_d[c] + 1);
    endfunction

    // Applies one rising edge using the inputs presented before it.
    function automatic void model_edge();
        edge_n++;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int c = 0; c < CHANNELS; c++) begin
            bit hit, boundary, upd_running;
            hit         = cfg_we && (int'(cfg_ch) == c);
            boundary    = m_en[c] && (phase_of(c, edge_n - 1) == m_d[c]);
            upd_running = hit && cfg_en && m_en[c];
            if (boundary) begin
                m_s[c] = edge_n;
`ifdef CLKDIV_GLITCHFREE_EN
                if (m_pend[c] && !upd_running) begin
                    m_d[c] = m_pdiv[c];
                    m_pend[c] = 0;
                end
`endif
            end
            if (hit) begin
                if (!cfg_en) begin
                    m_en[c] = 0; m_pend[c] = 0;
                end else if (!m_en[c]) begin
                    m_en[c] = 1; m_d[c] = int'(cfg_div); m_s[c] = edge_n; m_pend[c] = 0;
                end else begin
`ifdef CLKDIV_GLITCHFREE_EN
                    m_pdiv[c] = int'(cfg_div); m_pend[c] = 1;
`else
                    m_d[c] = int'(cfg_div); m_s[c] = edge_n;
`endif
                end
            end
        end
    endfunction

    task automatic check_outputs(input string where);
        for (int c = 0; c < CHANNELS; c++) begin
            bit e_tick, e_clk;
            int ph;
            e_tick = 0; e_clk = 0;
            if (m_en[c]) begin
                ph     = phase_of(c, edge_n);
                e_tick = (ph == m_d[c]);
                e_clk  = (ph <= m_d[c] / 2);
            end
            check_val($sformatf("%s tick[%0d]", where, c), 32'(ch_tick[c]), 32'(e_tick));
            check_val($sformatf("%s clk[%0d]", where, c),  32'(ch_clk[c]),  32'(e_clk));
            check_val($sformatf("%s pend[%0d]", where, c), 32'(ch_pend[c]), 32'(m_pend[c]));
        end
    endtask

    // ---------------------------------------------------------------- driver tasks
    task automatic step(input string where);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs(where);
    endtask

    task automatic idle(input int n, input string where);
        repeat (n) step(where);
    endtask

    task automatic cfg_write(input int ch, input int div, input bit en, input string where);
        cfg_we  = 1'b1;
        cfg_ch  = CH_W'(ch);
        cfg_div = DIV_W'(div);
        cfg_en  = en;
        step(where);
        cfg_we  = 1'b0;
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        edge_n = 0;
        model_reset();
        idle(2, "reset");
        rst_n = 1'b1;
        idle(3, "post_reset");

        // ch0 D=3: tick every 4th cycle, clk 1,1,0,0
        cfg_write(0, 3, 1, "ch0_d3");
        idle(13, "ch0_d3");

        // ch1 D=0 then D=2
        cfg_write(1, 0, 1, "ch1_d0");
        idle(4, "ch1_d0");
        cfg_write(1, 0, 0, "ch1_off");
        cfg_write(1, 2, 1, "ch1_d2");
        idle(7, "ch1_d2");

        // ratio change on a running channel at cnt=2
        cfg_write(0, 0, 0, "ch0_off");
        cfg_write(0, 5, 1, "ch0_d5");
        idle(2, "ch0_d5");
        cfg_write(0, 1, 1, "ch0_chg");
        idle(10, "ch0_chg");

        // disable mid-period (cnt=1, D=7)
        cfg_write(0, 0, 0, "ch0_off2");
        cfg_write(0, 7, 1, "ch0_d7");
        idle(1, "ch0_d7");
        cfg_write(0, 7, 0, "ch0_midoff");
        idle(2, "ch0_midoff");

        // out-of-range channel write
        cfg_write(CHANNELS, 9, 1, "oor");
        idle(3, "oor");
        cfg_write(CHANNELS + 1, 4, 0, "oor2");
        idle(2, "oor2");

        // widest divide value
        cfg_write(0, 255, 1, "ch0_dmax");
        idle(520, "ch0_dmax");

        // asynchronous reset between edges while counting
        cfg_write(1, 3, 1, "pre_rst");
        idle(3, "pre_rst");
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs("in_rst");
        rst_n = 1'b1;
        idle(6, "after_rst");

        // randomized writes
        repeat (2000) begin
            if ($urandom_range(0, 5) == 0) begin
                cfg_write($urandom_range(0, CHANNELS + 1), $urandom_range(0, 9),
                          $urandom_range(0, 3) != 0, "rand_wr");
            end else begin
                step("rand");
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    // Hard bound on run time.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d so far", pass_cnt, chk_cnt);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/clk_div_gen.md
# clk_div_gen

Parametrised multi-channel clock divider for the RISC-V core and its peripherals. From the single system clock it generates independent one-cycle tick pulses and near-50% divided clock-enable waveforms, one per channel, each with a run-time programmable ratio and enable. Slow peripherals, timers and debug strobes use these outputs as clock enables.

## Interface
- CHANNELS, 2: number of independent divider channels (1..16).
- DIV_W, 8: width of the per-channel divide value D; period is D+1 cycles.
- CH_W, 4: width of the channel select; must satisfy 2^CH_W >= CHANNELS.

- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cfg_we  input  1  configuration write strobe, sampled on rising clk.
- cfg_ch  input  CH_W  target channel for the write.
- cfg_div  input  DIV_W  divide value D to write.
- cfg_en  input  1  channel enable to write.
- ch_tick  output  CHANNELS  per-channel one-cycle pulse, once per period.
- ch_clk  output  CHANNELS  per-channel divided waveform, high ceil((D+1)/2) cycles per period.
- ch_pend  output  CHANNELS  per-channel flag: a divide change is waiting for the period boundary.

## Operation
- Per-channel state: div[DIV_W], en, cnt[DIV_W], pend, pdiv[DIV_W].
- Reset (rst_n low, asynchronous): all div, cnt, pdiv = 0; en = 0; pend = 0. Outputs ch_tick, ch_clk and ch_pend are 0 immediately and remain 0 until written.
- Counting when en = 1: cnt increments each edge. When cnt == div it wraps to 0. Arithmetic is unsigned, DIV_W bits, and cnt never exceeds div.
- ch_tick[i] = en & (cnt == div). This is a decode of state flops only, with no input path.
- ch_clk[i] = en & (cnt <= div>>1). D=0 gives ch_clk constant 1 and ch_tick constant 1 while enabled.
- Writes: cfg_we with cfg_ch >= CHANNELS is ignored, with no state change.
- Write with cfg_en = 0: en = 0, cnt = 0, pend = 0 at that edge. Outputs are 0 in the following cycle.
- Write with cfg_en = 1 to a disabled channel: div = cfg_div, en = 1, cnt = 0 at that edge.
- Write with cfg_en = 1 to an enabled channel: behaviour depends on the macro (see Configuration).
- A write at the same edge as a wrap follows the write rules. The write wins over the wrap.
- Channels are fully independent. Only one channel is written per cycle.

## Timing
- Configuration latency is one edge: a write sampled at edge E is visible in state after E.
- After enabling with D at edge E, the first ch_tick is high in the cycle following edge E+D. Subsequent ticks follow every D+1 cycles.
- ch_clk rises in the cycle after edge E, together with cnt = 0.
- Disabling is immediate: outputs are low in the cycle after the write edge, even mid-period.
- Reset assertion is asynchronous, mid-period or otherwise. After deassertion, channels stay disabled until written.

## Configuration
- CLKDIV_GLITCHFREE_EN defined:
  - A cfg_en = 1 write to an enabled channel stores cfg_div in pdiv and sets pend = 1. The current period completes unchanged.
  - At the next edge where cnt == div, the channel sets div = pdiv, cnt = 0 and pend = 0.
  - A later pending write overwrites pdiv. A disable write clears pend.
  - No truncated or stretched period is ever produced.
- CLKDIV_GLITCHFREE_EN undefined:
  - A cfg_en = 1 write to an enabled channel sets div = cfg_div and cnt = 0 at that edge. The current period is truncated.
  - pdiv and pend logic is removed, and ch_pend is tied to 0.

## Test plan
- Reset, then enable ch0 with D=3 at edge E -> ch_tick[0] high only in cycles E+4, E+8, E+12. ch_clk[0] pattern 1,1,0,0 repeating. ch1 stays 0.
- ch1 with D=0 and D=2 -> D=0: ch_tick[1] and ch_clk[1] constant 1. D=2: ch_clk[1] pattern 1,1,0 and tick every 3rd cycle.
- Write ch0 D=1 while running D=5 at cnt=2 -> with macro: ch_pend[0] = 1, remaining ticks at the old boundary, then period 2 and pend = 0. Without macro: cnt = 0 at once, period 2 starting next cycle.
- Disable ch0 mid-period (cnt=1, D=7), and separately write cfg_ch = CHANNELS -> ch0 outputs 0 next cycle with cnt = 0. The out-of-range write changes no state on any channel.
- Assert rst_n low between edges during active counting -> all outputs 0 without waiting for clk. After release, no ticks until a new enable write.
